// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, valid/ready memory requests and an in-order buffer toward decode.
// Optional misaligned-redirect trap is built when FETCH_MISALIGN_TRAP_EN is defined.
//
// state | meaning
// RUN   | normal fetch and delivery to decode
// TRAP  | misaligned redirect target seen; fetch halted until reset or an aligned redirect
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        o_misalign
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     pc_mem_q    [DEPTH];

    logic [31:0]     redirect_target;
    logic            redirect_misaligned;
    logic [CW-1:0]   inflight_live;
    logic [CW:0]     occupancy;
    logic            req_valid;
    logic            req_fire;
    logic            head_valid;
    logic            push;
    logic            pop;

    assign redirect_target = {i_redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    logic [31:0] trap_pc_q, trap_pc_d;
    assign redirect_misaligned = |i_redirect_pc[1:0];
`else
    logic redirect_lsb_unused;
    assign redirect_lsb_unused = ^i_redirect_pc[1:0];
    assign redirect_misaligned = 1'b0;
`endif

    // Stale responses still count against inflight but will never land in the buffer.
    assign inflight_live = inflight_q - drop_cnt_q;
    assign occupancy     = {1'b0, inflight_live} + {1'b0, count_q};
    assign req_valid     = !i_rst && (state_q == ST_RUN) && !i_redirect
                           && (occupancy < (CW+1)'(DEPTH));
    assign req_fire      = req_valid && i_imem_req_ready;
    assign head_valid    = !i_rst && (state_q == ST_RUN) && (count_q != '0);
    assign pop           = head_valid && i_ready && !i_redirect;
    assign push          = !i_rst && i_imem_rsp_valid && !i_redirect && (drop_cnt_q == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_pc_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_pc_q  <= trap_pc_d;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= i_imem_rsp_data;
            pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_pc_d = trap_pc_q;
        if (i_redirect) begin
            if (redirect_misaligned) begin
                state_d   = ST_TRAP;
                trap_pc_d = i_redirect_pc;
            end else begin
                state_d = ST_RUN;
            end
        end
`else
        if (redirect_misaligned) begin
            state_d = ST_TRAP;
        end
`endif
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (i_redirect) begin
            // A response landing in the redirect cycle is already stale, so it is not counted as a drop.
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            inflight_d = inflight_q - CW'(i_imem_rsp_valid);
            drop_cnt_d = inflight_q - CW'(i_imem_rsp_valid);
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
        end else begin
            inflight_d = inflight_q + CW'(req_fire) - CW'(i_imem_rsp_valid);
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (i_imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        o_imem_req_valid = req_valid;
        o_imem_addr      = fetch_pc_q;
        o_valid          = head_valid;
        o_instr          = instr_mem_q[rd_ptr_q];
        o_pc             = pc_mem_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_TRAP_EN
        o_misalign       = !i_rst && (state_q == ST_TRAP);
        if (state_q == ST_TRAP) begin
            o_pc = trap_pc_q;
        end
`endif
    end

    a_no_rsp_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_imem_rsp_valid && (inflight_q == '0)));
    a_drop_within_inflight: assert property (@(posedge i_clk) disable iff (i_rst)
        drop_cnt_q <= inflight_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based memory and delivery model compared every cycle, plus directed literal checks.
module tb_fetch_unit;
    localparam int DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req_valid;
    logic [31:0] o_imem_addr;
    logic        i_imem_req_ready;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        o_misalign;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .o_imem_req_valid(o_imem_req_valid),
        .o_imem_addr     (o_imem_addr),
        .i_imem_req_ready(i_imem_req_ready),
        .i_imem_rsp_valid(i_imem_rsp_valid),
        .i_imem_rsp_data (i_imem_rsp_data),
        .o_valid         (o_valid),
        .o_instr         (o_instr),
        .o_pc            (o_pc),
        .i_ready         (i_ready),
        .i_redirect      (i_redirect),
        .i_redirect_pc   (i_redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .o_misalign      (o_misalign)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    mreq_t       memq[$];
    word_t       bufq[$];
    logic [31:0] fired[$];
    logic [31:0] popped[$];
    logic [31:0] next_pc;
    bit          trap;
    logic [31:0] trap_pc;
    int          cyc;
    int          lat;
    int          errors;
    int          checks;

    logic        s_valid, s_req_valid, s_misalign;
    logic [31:0] s_pc, s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive the memory response, compare against the model, then advance the model.
    task automatic step();
        bit    rsp, exp_v, exp_rv, fire, pop;
        int    live;
        mreq_t w;
        rsp = !i_rst && (memq.size() > 0) && (memq[0].due <= cyc);
        i_imem_rsp_valid = rsp;
        i_imem_rsp_data  = rsp ? mem_word(memq[0].addr) : 32'hDEAD_BEEF;
        #3;
        live = 0;
        foreach (memq[k]) if (!memq[k].stale) live++;
        exp_v  = !i_rst && !trap && (bufq.size() > 0);
        exp_rv = !i_rst && !trap && !i_redirect && ((live + bufq.size()) < DEPTH);
        s_valid = o_valid; s_req_valid = o_imem_req_valid; s_pc = o_pc; s_addr = o_imem_addr;
        check("req_valid", o_imem_req_valid, exp_rv);
        check("valid", o_valid, exp_v);
        if (!i_rst) check("imem_addr", o_imem_addr, next_pc);
        if (exp_v) begin
            check("head_pc", o_pc, bufq[0].pc);
            check("head_instr", o_instr, bufq[0].instr);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        s_misalign = o_misalign;
        if (!i_rst) check("misalign", o_misalign, trap);
        if (!i_rst && trap) check("trap_pc", o_pc, trap_pc);
`else
        s_misalign = 1'b0;
`endif
        fire = exp_rv && i_imem_req_ready;
        pop  = exp_v && i_ready && !i_redirect;
        if (i_rst) begin
            memq.delete();
            bufq.delete();
            next_pc = RESET_PC;
            trap = 0;
        end else begin
            if (fire) begin
                memq.push_back('{addr: next_pc, due: cyc + lat, stale: 1'b0});
                fired.push_back(next_pc);
                next_pc = next_pc + 32'd4;
            end
            if (pop) begin
                popped.push_back(bufq[0].pc);
                void'(bufq.pop_front());
            end
            if (rsp) begin
                w = memq.pop_front();
                if (!w.stale && !i_redirect) bufq.push_back('{pc: w.addr, instr: mem_word(w.addr)});
            end
            if (i_redirect) begin
                foreach (memq[k]) memq[k].stale = 1'b1;
                bufq.delete();
                next_pc = {i_redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
                if (i_redirect_pc[1:0] != 2'b00) begin
                    trap = 1;
                    trap_pc = i_redirect_pc;
                end else begin
                    trap = 0;
                end
`endif
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_redirect = 1'b0;
        repeat (2) step();
        i_rst = 1'b0;
        fired.delete();
        popped.delete();
    endtask

    function automatic int live_count();
        int n = 0;
        foreach (memq[k]) if (!memq[k].stale) n++;
        return n;
    endfunction

    initial begin
        int  first_valid;
        bit  found, saw_stale;
        errors = 0; checks = 0; cyc = 0; lat = 1;
        trap = 0; trap_pc = '0; next_pc = RESET_PC;
        i_rst = 1'b1; i_ready = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;
        i_imem_req_ready = 1'b1; i_imem_rsp_valid = 1'b0; i_imem_rsp_data = '0;
        @(posedge clk); #1;

        // Reset and streaming with 1-cycle memory
        repeat (2) step();
        do_reset();
        first_valid = -1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (s_valid && first_valid < 0) first_valid = k;
        end
        check("first_valid_cycle", first_valid, 2);
        check("fired0", fired[0], 32'h0);
        check("fired1", fired[1], 32'h4);
        check("fired2", fired[2], 32'h8);
        check("popped0", popped[0], 32'h0);
        check("popped1", popped[1], 32'h4);
        check("popped2", popped[2], 32'h8);

        // Decode stall: only DEPTH requests issued, head held at pc 0
        do_reset();
        i_ready = 1'b0;
        repeat (10) step();
        check("stall_fired", fired.size(), 2);
        check("stall_popped", popped.size(), 0);
        check("stall_head_pc", s_pc, 32'h0);
        check("stall_valid", s_valid, 1'b1);
        i_ready = 1'b1;
        repeat (10) step();
        check("resume0", popped[0], 32'h0);
        check("resume1", popped[1], 32'h4);
        check("resume2", popped[2], 32'h8);
        check("resume3", popped[3], 32'hC);

        // Redirect with two requests in flight at latency 3
        do_reset();
        lat = 3;
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (live_count() == 2 && fired.size() >= 4) found = 1;
            else step();
        end
        check("t3_inflight_found", found, 1'b1);
        i_redirect = 1'b1; i_redirect_pc = 32'h100;
        step();
        i_redirect = 1'b0;
        popped.delete();
        repeat (14) step();
        check("t3_first_pc", popped[0], 32'h100);
        saw_stale = 0;
        foreach (popped[k]) if (popped[k] == 32'h8 || popped[k] == 32'hC) saw_stale = 1;
        check("t3_no_stale", saw_stale, 1'b0);

        // Redirect in a cycle with a response and a pop
        do_reset();
        lat = 1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (bufq.size() > 0 && memq.size() > 0 && memq[0].due <= cyc) found = 1;
            else step();
        end
        check("t4_cond_found", found, 1'b1);
        i_redirect = 1'b1; i_redirect_pc = 32'h200;
        step();
        i_redirect = 1'b0;
        popped.delete();
        step();
        check("t4_empty", s_valid, 1'b0);
        check("t4_req_valid", s_req_valid, 1'b1);
        check("t4_req_addr", s_addr, 32'h200);
        repeat (6) step();
        check("t4_first_pc", popped[0], 32'h200);

        // Memory back-pressure, then PC wrap
        do_reset();
        i_imem_req_ready = 1'b0;
        repeat (5) begin
            step();
            check("t5_addr_held", s_addr, 32'h0);
        end
        check("t5_no_fire", fired.size(), 0);
        i_imem_req_ready = 1'b1;
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
        step();
        i_redirect = 1'b0;
        fired.delete(); popped.delete();
        repeat (8) step();
        check("wrap_fire0", fired[0], 32'hFFFF_FFFC);
        check("wrap_fire1", fired[1], 32'h0);
        check("wrap_pop0", popped[0], 32'hFFFF_FFFC);
        check("wrap_pop1", popped[1], 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect traps; aligned redirect recovers
        do_reset();
        repeat (3) step();
        i_redirect = 1'b1; i_redirect_pc = 32'h102;
        step();
        i_redirect = 1'b0;
        fired.delete();
        repeat (4) begin
            step();
            check("trap_flag", s_misalign, 1'b1);
            check("trap_pc_lit", s_pc, 32'h102);
            check("trap_no_req", s_req_valid, 1'b0);
        end
        i_redirect = 1'b1; i_redirect_pc = 32'h107;
        step();
        i_redirect = 1'b0;
        step();
        check("trap_pc_upd", s_pc, 32'h107);
        i_redirect = 1'b1; i_redirect_pc = 32'h300;
        step();
        i_redirect = 1'b0;
        step();
        check("trap_exit", s_misalign, 1'b0);
        check("trap_exit_req", s_req_valid, 1'b1);
        check("trap_exit_addr", s_addr, 32'h300);
        check("trap_fired", fired.size(), 1);
        repeat (4) step();
`else
        // Low address bits of a redirect target are ignored
        do_reset();
        repeat (3) step();
        i_redirect = 1'b1; i_redirect_pc = 32'h102;
        step();
        i_redirect = 1'b0;
        fired.delete(); popped.delete();
        repeat (6) step();
        check("align_fire0", fired[0], 32'h100);
        check("align_pop0", popped[0], 32'h100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
